// File: rtl/extremity_switches_supervisor.sv
// extremity_switches_supervisor: debounces and qualifies the two extremity switches of an axis,
// gates step requests away from a reached extremity and generates the shared LED blinker.
package extremity_switches_supervisor_pkg;
   typedef struct packed {
      logic clk;
      logic reset;
   } ckrs_t;
   typedef struct packed {
      logic       Polarity;
      logic [1:0] SelectedInputSwitches_b2;
   } switchstate_t;
endpackage

module extremity_switches_supervisor
   import extremity_switches_supervisor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 25000,
   parameter int BLINK_HALF_PERIOD = 6250000
) (
   input  ckrs_t              ClkRs_ix,
   input  logic [1:0]         rawswitches,
   input  switchstate_t [1:0] switchesconfig,
   input  logic               step_req_i,
   input  logic               dir_i,
   output logic               step_ack_o,
   output logic               step_nack_o,
   output logic               step_o,
   output logic               dir_o,
   output logic [1:0]         debounced_o,
   output logic               extremity_out_o,
   output logic               extremity_in_o,
   output logic               fault_o,
   output logic               blinker_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);

   typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;

   logic clk, rst_n;
   assign clk   = ClkRs_ix.clk;
   assign rst_n = ClkRs_ix.reset;

   logic [1:0]         sync1_q, sync2_q, stable_q, stable_d, corr;
   logic [CW-1:0]      deb_cnt_q [2];
   logic [CW-1:0]      deb_cnt_d [2];
   switchstate_t [1:0] cfg_q;
   logic               loaded_q;
   state_t             state_q, state_d;
   logic [CW-1:0]      settle_q, settle_d;
   logic               ext_out_q, ext_out_d, ext_in_q, ext_in_d;
   logic               ack_q, ack_d, nack_q, nack_d, dir_q, dir_d;
   logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
   logic               blink_q, blink_d;
   logic               cfg_chg, fault_cond, grant, busy;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         stable_d[i]  = stable_q[i];
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (deb_cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) stable_d[i] = sync2_q[i];
            else deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
         end
         corr[i] = stable_q[i] ^ switchesconfig[i].Polarity;
      end
      ext_out_d  = |(corr & switchesconfig[0].SelectedInputSwitches_b2);
      ext_in_d   = |(corr & switchesconfig[1].SelectedInputSwitches_b2);
      // the first cycle after reset only loads the config register
      cfg_chg    = loaded_q && (switchesconfig != cfg_q);
      fault_cond = (switchesconfig[0].SelectedInputSwitches_b2 == 2'b00) ||
                   (switchesconfig[1].SelectedInputSwitches_b2 == 2'b00) ||
                   (ext_out_q && ext_in_q);
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         INIT: begin
            if (cfg_chg) settle_d = '0;
            else if (settle_q == CW'(DEBOUNCE_CYCLES - 1)) state_d = RUN;
            else settle_d = settle_q + CW'(1);
         end
         RUN: begin
            if (fault_cond) state_d = FAULT;
            else if (cfg_chg) begin
               state_d  = INIT;
               settle_d = '0;
            end
         end
         FAULT: begin
            if (!fault_cond) begin
               state_d  = INIT;
               settle_d = '0;
            end
         end
         default: state_d = INIT;
      endcase
      busy   = ack_q || nack_q;
      grant  = (state_q == RUN) && (dir_i ? !ext_out_q : !ext_in_q);
      ack_d  = step_req_i && !busy && grant;
      nack_d = step_req_i && !busy && !grant;
      dir_d  = ack_d ? dir_i : dir_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q + BW'(1);
      if (blink_cnt_q == BW'(BLINK_HALF_PERIOD - 1)) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         deb_cnt_q[0] <= '0;
         deb_cnt_q[1] <= '0;
         cfg_q        <= '0;
         loaded_q     <= 1'b0;
         state_q      <= INIT;
         settle_q     <= '0;
         ext_out_q    <= 1'b0;
         ext_in_q     <= 1'b0;
         ack_q        <= 1'b0;
         nack_q       <= 1'b0;
         dir_q        <= 1'b0;
         blink_cnt_q  <= '0;
         blink_q      <= 1'b0;
      end else begin
         sync1_q      <= rawswitches;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         deb_cnt_q[0] <= deb_cnt_d[0];
         deb_cnt_q[1] <= deb_cnt_d[1];
         cfg_q        <= switchesconfig;
         loaded_q     <= 1'b1;
         state_q      <= state_d;
         settle_q     <= settle_d;
         ext_out_q    <= ext_out_d;
         ext_in_q     <= ext_in_d;
         ack_q        <= ack_d;
         nack_q       <= nack_d;
         dir_q        <= dir_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_q      <= blink_d;
      end
   end

   assign step_ack_o      = ack_q;
   assign step_nack_o     = nack_q;
   assign step_o          = ack_q;
   assign dir_o           = dir_q;
   assign debounced_o     = stable_q;
   assign extremity_out_o = ext_out_q;
   assign extremity_in_o  = ext_in_q;
   assign fault_o         = (state_q == FAULT);
   assign blinker_o       = blink_q;
endmodule

// File: tb/tb_extremity_switches_supervisor.sv
// tb_extremity_switches_supervisor: directed scenarios plus random traffic against a behavioural model.
module tb_extremity_switches_supervisor;
   import extremity_switches_supervisor_pkg::*;
   localparam int D = 4;
   localparam int H = 3;

   logic clk = 1'b0, rst_n = 1'b1;
   ckrs_t ckrs;
   assign ckrs = '{clk: clk, reset: rst_n};
   logic [1:0] raw = 2'b00;
   switchstate_t [1:0] cfg;
   logic req = 1'b0, dir = 1'b0;
   logic step_ack_o, step_nack_o, step_o, dir_o, extremity_out_o, extremity_in_o, fault_o, blinker_o;
   logic [1:0] debounced_o;
   int nvec = 0, errs = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   extremity_switches_supervisor #(.DEBOUNCE_CYCLES(D), .BLINK_HALF_PERIOD(H)) dut (
      .ClkRs_ix(ckrs), .rawswitches(raw), .switchesconfig(cfg), .step_req_i(req), .dir_i(dir),
      .step_ack_o(step_ack_o), .step_nack_o(step_nack_o), .step_o(step_o), .dir_o(dir_o),
      .debounced_o(debounced_o), .extremity_out_o(extremity_out_o), .extremity_in_o(extremity_in_o),
      .fault_o(fault_o), .blinker_o(blinker_o));

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic switchstate_t mk(input logic p, input logic [1:0] s);
      return '{Polarity: p, SelectedInputSwitches_b2: s};
   endfunction

   // model: mode 0 = INIT, 1 = RUN, 2 = FAULT; a bit flips once D synced samples in a row disagree
   logic [1:0] m_s1 = 0, m_s2 = 0, m_deb = 0, t_syn, t_deb, t_c;
   logic [1:0] m_sh [$];
   switchstate_t [1:0] m_cfg = '0;
   logic m_eo = 0, m_ei = 0, m_ack = 0, m_nack = 0, m_dir = 0, m_loaded = 0;
   logic t_all, t_eo, t_ei, t_fc, t_chg, t_busy, t_grant;
   int m_mode = 0, m_quiet = 0, m_cyc = 0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_deb = 0; m_sh.delete(); m_eo = 0; m_ei = 0; m_mode = 0; m_quiet = 0;
         m_loaded = 0; m_ack = 0; m_nack = 0; m_dir = 0; m_cyc = 0; m_cfg = '0;
      end else begin
         t_syn = m_s2;
         m_sh.push_back(t_syn);
         if (m_sh.size() > D) void'(m_sh.pop_front());
         t_deb = m_deb;
         for (int i = 0; i < 2; i++) begin
            t_all = (m_sh.size() == D);
            for (int k = 0; k < m_sh.size(); k++) if (m_sh[k][i] == m_deb[i]) t_all = 0;
            if (t_all) t_deb[i] = ~m_deb[i];
            t_c[i] = m_deb[i] ^ cfg[i].Polarity;
         end
         t_eo = |(t_c & cfg[0].SelectedInputSwitches_b2);
         t_ei = |(t_c & cfg[1].SelectedInputSwitches_b2);
         t_fc = (cfg[0].SelectedInputSwitches_b2 == 2'b00) || (cfg[1].SelectedInputSwitches_b2 == 2'b00) || (m_eo && m_ei);
         t_chg = m_loaded && (cfg != m_cfg);
         t_busy = m_ack || m_nack;
         t_grant = (m_mode == 1) && (dir ? !m_eo : !m_ei);
         m_ack = req && !t_busy && t_grant;
         m_nack = req && !t_busy && !t_grant;
         if (m_ack) m_dir = dir;
         if (m_mode == 0) begin
            m_quiet = t_chg ? 0 : m_quiet + 1;
            if (m_quiet == D) m_mode = 1;
         end else if (m_mode == 1) begin
            if (t_fc) m_mode = 2;
            else if (t_chg) begin m_mode = 0; m_quiet = 0; end
         end else if (!t_fc) begin
            m_mode = 0; m_quiet = 0;
         end
         m_deb = t_deb; m_eo = t_eo; m_ei = t_ei; m_cfg = cfg; m_loaded = 1;
         m_s2 = m_s1; m_s1 = raw; m_cyc++;
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("ack", int'(step_ack_o), int'(m_ack));
         chk("nack", int'(step_nack_o), int'(m_nack));
         chk("step", int'(step_o), int'(m_ack));
         chk("dir", int'(dir_o), int'(m_dir));
         chk("debounced", int'(debounced_o), int'(m_deb));
         chk("ext_out", int'(extremity_out_o), int'(m_eo));
         chk("ext_in", int'(extremity_in_o), int'(m_ei));
         chk("fault", int'(fault_o), int'(m_mode == 2));
         chk("blinker", int'(blinker_o), ((m_cyc / H) % 2));
      end
   end

   task automatic chk_zero(input string nm);
      chk({nm, "_ack"}, int'(step_ack_o), 0);
      chk({nm, "_nack"}, int'(step_nack_o), 0);
      chk({nm, "_dir"}, int'(dir_o), 0);
      chk({nm, "_deb"}, int'(debounced_o), 0);
      chk({nm, "_ext"}, int'({extremity_out_o, extremity_in_o}), 0);
      chk({nm, "_fault"}, int'(fault_o), 0);
      chk({nm, "_blink"}, int'(blinker_o), 0);
   endtask

   initial begin
      int na;
      cfg[0] = mk(1'b0, 2'b01);
      cfg[1] = mk(1'b0, 2'b10);
      #1 rst_n = 1'b0;
      cyc(2);
      chk_en = 1;
      chk_zero("reset");
      rst_n = 1'b1; req = 1'b1; dir = 1'b1;
      cyc(1); chk("init_nack", int'(step_nack_o), 1); chk("init_no_ack", int'(step_ack_o), 0);
      cyc(1); chk("blind_nack", int'(step_nack_o), 0); chk("blink_lo", int'(blinker_o), 0);
      cyc(1); chk("init_nack2", int'(step_nack_o), 1); chk("blink_hi", int'(blinker_o), 1);
      cyc(2); chk("run_ack", int'(step_ack_o), 1); chk("run_step", int'(step_o), 1); chk("run_dir", int'(dir_o), 1);
      req = 1'b0;
      cyc(1); chk("blink_lo2", int'(blinker_o), 0);
      // short glitch must be swallowed
      raw = 2'b01; cyc(3); raw = 2'b00;
      for (int k = 0; k < 10; k++) begin cyc(1); chk("glitch_deb", int'(debounced_o), 0); end
      raw = 2'b01;
      cyc(5); chk("deb_before", int'(debounced_o[0]), 0);
      cyc(1); chk("deb_edge", int'(debounced_o[0]), 1); chk("ext_before", int'(extremity_out_o), 0);
      cyc(1); chk("ext_edge", int'(extremity_out_o), 1);
      req = 1'b1; dir = 1'b1; cyc(1); chk("out_nack", int'(step_nack_o), 1);
      req = 1'b0; cyc(1);
      req = 1'b1; dir = 1'b0; cyc(1); chk("in_ack", int'(step_ack_o), 1);
      req = 1'b0;
      raw = 2'b00; cyc(8);
      cfg[0] = mk(1'b1, 2'b01); cyc(8);
      chk("pol_ext", int'(extremity_out_o), 1); chk("pol_nofault", int'(fault_o), 0);
      req = 1'b1; dir = 1'b1; cyc(1); chk("pol_nack", int'(step_nack_o), 1);
      req = 1'b0; cyc(1);
      raw = 2'b10; cyc(9); chk("both_fault", int'(fault_o), 1);
      req = 1'b1; dir = 1'b0; cyc(1); chk("fault_nack", int'(step_nack_o), 1);
      req = 1'b0; cyc(1);
      raw = 2'b00; cyc(14); chk("fault_clear", int'(fault_o), 0);
      req = 1'b1; dir = 1'b0; cyc(1); chk("recover_ack", int'(step_ack_o), 1);
      req = 1'b0; cyc(1);
      cfg[1] = mk(1'b0, 2'b00); cyc(2); chk("sel00_fault", int'(fault_o), 1);
      cfg[0] = mk(1'b0, 2'b01); cfg[1] = mk(1'b0, 2'b10); cyc(8);
      req = 1'b1; dir = 1'b1; cyc(3);
      cfg[1] = mk(1'b1, 2'b10); cyc(1);
      for (int k = 0; k < 4; k++) begin cyc(1); chk("cfgchg_no_ack", int'(step_ack_o), 0); end
      na = 0;
      for (int k = 0; k < 6; k++) begin cyc(1); na += int'(step_ack_o); end
      chk("ack_resume", na, 3);
      cyc(1);
      rst_n = 1'b0; #2;
      chk_zero("async_rst");
      cyc(2);
      req = 1'b0; rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin cyc(1); chk("no_stray_ack", int'(step_ack_o | step_nack_o), 0); end
      chk("blink_after_rst", int'(blinker_o), 1);
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(15) == 0) raw ^= 2'($urandom_range(2, 1));
         if ($urandom_range(79) == 0)
            for (int j = 0; j < 2; j++)
               cfg[j] = mk(1'($urandom_range(1)), ($urandom_range(7) == 0) ? 2'b00 : 2'($urandom_range(3, 1)));
         req = ($urandom_range(3) != 0);
         dir = 1'($urandom_range(1));
         if ($urandom_range(499) == 0) begin
            rst_n = 1'b0; #2;
            chk_zero("rand_rst");
            cyc(1);
            rst_n = 1'b1;
         end
         cyc(1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end
endmodule

// File: doc/extremity_switches_supervisor.md
# extremity_switches_supervisor

Debounces the two raw extremity switches of one motor axis, qualifies them against the per-switch configuration, and gates the axis step requests so the motor cannot be driven further into a reached extremity. It sits between the GEFE switch inputs and the stepper pulse generator, and it feeds the front-panel LED mapper. It also generates the shared LED `blinker_o` signal.

## Interface
- `DEBOUNCE_CYCLES`, default 25000: stable-input window. At 25 MHz this is 1 ms. Must be ≥ 2.
- `BLINK_HALF_PERIOD`, default 6250000: blinker half period in clocks (250 ms). Must be ≥ 1.
- `ClkRs_ix` input ckrs_t: `.clk` is the rising-edge 25 MHz clock; `.reset` is the reset, asynchronous and active-low.
- `rawswitches` input [1:0]: raw switch levels, asynchronous to `.clk`.
- `switchesconfig` input switchstate_t [1:0]: per switch `.Polarity` and `.SelectedInputSwitches_b2`. Index 0 is the OUT extremity, index 1 is the IN extremity.
- `step_req_i` input 1: step request (level).
- `dir_i` input 1: direction of the request; 1 = OUT, 0 = IN.
- `step_ack_o` output 1: one-cycle pulse; the step is granted.
- `step_nack_o` output 1: one-cycle pulse; the step is refused.
- `step_o` output 1: one-cycle step pulse to the pulse generator. Equal to `step_ack_o`.
- `dir_o` output 1: registered direction of the last granted step.
- `debounced_o` output [1:0]: debounced raw levels, before polarity correction.
- `extremity_out_o` output 1: OUT extremity reached.
- `extremity_in_o` output 1: IN extremity reached.
- `fault_o` output 1: the block is in the FAULT state.
- `blinker_o` output 1: LED blink square wave.

## Operation
- **Synchronizer:** two flip-flop stages per bit of `rawswitches`.
- **Debounce, per bit:**
  - The counter clears whenever the synchronized bit equals the stable bit.
  - Otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the bits still differ, the stable bit takes the synchronized value and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- **Correction:** `c[i] = debounced[i] ^ switchesconfig[i].Polarity`.
- **Extremity qualification:**
  - OUT = OR of the `c[j]` for which bit j of `switchesconfig[0].SelectedInputSwitches_b2` is 1.
  - IN uses `switchesconfig[1]` in the same way.
  - Both are registered into `extremity_out_o` / `extremity_in_o`.
- **Config watch:** `switchesconfig` is registered every cycle. Any difference from the previous value is a config change.
- **FSM states:** INIT, RUN, FAULT.
  - **INIT:** entered on reset, on any config change, and on FAULT clearing. A settle counter counts `DEBOUNCE_CYCLES` cycles, then the FSM goes to RUN. A config change during INIT restarts the count.
  - **RUN:** goes to FAULT if either `SelectedInputSwitches_b2 == 2'b00`, or `extremity_out_o && extremity_in_o`. Goes to INIT on a config change. The fault check has priority over the config change.
  - **FAULT:** `fault_o = 1`. When the fault condition has been false for one cycle, the FSM goes to INIT. A config change is absorbed; the fault condition is re-evaluated with the new config.
- **Step handshake:**
  - The block samples `step_req_i` in cycle N. Exactly one of `step_ack_o` / `step_nack_o` pulses in cycle N+1.
  - The cycle of a response is blind: `step_req_i` is ignored there. The maximum rate is therefore one step per 2 cycles. A held request produces a response every other cycle.
  - ACK only if state is RUN and the requested extremity is not reached: `dir_i=1` needs `!extremity_out_o`; `dir_i=0` needs `!extremity_in_o`. Everything else gets NACK.
  - `dir_o` updates with each ACK.
- **Blinker:** a free-running counter toggles `blinker_o` every `BLINK_HALF_PERIOD` cycles, independent of the FSM.
- **Reset values:**
  - All outputs are 0.
  - Stable bits are 0 and all counters are 0.
  - The config register is loaded from the input at reset release, so release is not a config change.
  - State is INIT.
- **Reset mid-operation:** everything returns to reset values immediately (asynchronous). No pending response is emitted.

## Timing
- Raw edge sampled at edge k: synchronized at k+2, `debounced_o` at k+2+D, extremity output at k+3+D. Here D = `DEBOUNCE_CYCLES`.
- A glitch shorter than D synchronized cycles never reaches `debounced_o`.
- Request to response latency: 1 cycle. The extremity value used is the registered one in the sampling cycle.
- Config change at cycle c: state is INIT from c+1. RUN is re-entered at c+1+D if there is no further change.
- `blinker_o` first rises `BLINK_HALF_PERIOD` cycles after reset release; period is 2×`BLINK_HALF_PERIOD`.

## Test plan
All scenarios use D=4, BLINK_HALF_PERIOD=3.

1. **Reset and init:** config[0]/[1] = sel 01/10, polarity 0. Release reset → state INIT for 4 cycles. A request in INIT → NACK. After INIT, request dir=1 → ACK plus `step_o` one cycle later.
2. **Debounce:** a 3-cycle high pulse on `rawswitches[0]` → `debounced_o` stays 00. Hold high for 10 cycles → `debounced_o[0]` rises 6 cycles after the raw edge and `extremity_out_o` one cycle later. Then dir=1 → NACK and dir=0 → ACK.
3. **Polarity:** config[0].Polarity=1 with raw 0 → `extremity_out_o`=1 after settle. Request dir=1 → NACK.
4. **Fault:** both extremities asserted → `fault_o`=1 and all requests NACK. Release one switch → after debounce, FAULT → INIT → RUN (4 cycles) and requests are ACKed again. Separately, set sel=00 → FAULT.
5. **Config change mid-run:** change config[1].Polarity while step requests are held high. Requests are NACKed for 4 cycles, then ACKs resume every other cycle.
6. **Blinker and async reset:** `blinker_o` toggles every 3 cycles. Asserting reset mid-handshake clears all outputs in the same cycle, with no stray ACK after release.
